// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and default width for the PWM duty ramp sequencer
package pwm_pkg;
  localparam int N_DEF = 8;
  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_e;
endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running n-bit period counter with enable and wrap strobe
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int n = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  output logic [n-1:0] cnt,
  output logic         wrap
);
  logic [n-1:0] cnt_q, cnt_d;
  always_comb cnt_d = enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
  assign cnt  = cnt_q;
  assign wrap = enable & (&cnt_q);
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl: ramps PWM duty toward an accepted target by one step per period,
// changing duty only on period boundaries.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int n = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [n-1:0] tgt_duty,
  input  logic [n-1:0] tgt_step,
  output logic [n-1:0] duty,
  output logic         period_start,
  output logic         busy,
  output logic         done
);
  state_e       state_q, state_d;
  logic [n-1:0] duty_q, duty_d, tgt_q, tgt_d, step_q, step_d;
  logic         done_q, done_d;
  logic [n-1:0] cnt;
  logic         wrap, up;
  logic [n:0]   diff;
  pwm_period_counter #(.n(n)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .cnt    (cnt),
    .wrap   (wrap)
  );
  assign up   = tgt_q > duty_q;
  assign diff = up ? {1'b0, tgt_q} - {1'b0, duty_q} : {1'b0, duty_q} - {1'b0, tgt_q};
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (tgt_valid) begin
        tgt_d   = tgt_duty;
        step_d  = tgt_step;
        done_d  = tgt_duty == duty_q;
        state_d = tgt_duty == duty_q ? IDLE : RAMP;
      end
    end else if (wrap) begin
      // final step lands exactly on target so overshoot is impossible
      if (step_q == '0 || diff <= {1'b0, step_q}) begin
        duty_d  = tgt_q;
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        duty_d = up ? duty_q + step_q : duty_q - step_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end
  assign tgt_ready    = state_q == IDLE;
  assign busy         = state_q == RAMP;
  assign duty         = duty_q;
  assign done         = done_q;
  assign period_start = cnt == '0;
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb_pwm_duty_ramp_ctrl: directed stimulus with a queued scoreboard of expected duty/done events
module tb_pwm_duty_ramp_ctrl;
  logic       clk = 1'b0;
  logic       reset, enable, tgt_valid;
  logic [7:0] tgt_duty, tgt_step;
  logic       tgt_ready, period_start, busy, done;
  logic [7:0] duty;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [7:0] duty; logic done;} ev_t;
  ev_t exp_q[$];
  pwm_duty_ramp_ctrl #(.n(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tgt_valid    (tgt_valid),
    .tgt_ready    (tgt_ready),
    .tgt_duty     (tgt_duty),
    .tgt_step     (tgt_step),
    .duty         (duty),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );
  always #5 clk = ~clk;

  logic [7:0] prev_duty = 8'd0;
  always @(negedge clk) begin
    if (reset === 1'b1 && (duty !== prev_duty || done === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event duty=%0d done=%0b, none expected", duty, done);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (duty !== e.duty || done !== e.done) begin
          errors++;
          $display("FAIL event duty=%0d done=%0b, expected duty=%0d done=%0b", duty, done, e.duty, e.done);
        end
      end
    end
    prev_duty = duty;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic dn);
    exp_q.push_back({d, dn});
  endtask

  task automatic wait_ps();
    int k = 0;
    while (!period_start && k < 300) begin tick(1); k++; end
    chk("wait_period_start_timeout", int'(period_start), 1);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] s);
    int k = 0;
    tgt_valid = 1'b1; tgt_duty = d; tgt_step = s;
    while (!tgt_ready && k < 2000) begin tick(1); k++; end
    chk("send_ready_timeout", int'(tgt_ready), 1);
    tick(1);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!tgt_ready && k < 2000) begin tick(1); k++; end
    chk("wait_idle_timeout", int'(tgt_ready), 1);
    tick(2);
  endtask

  initial begin
    int k;
    bit saw_ps;
    reset = 1'b0; enable = 1'b1; tgt_valid = 1'b0; tgt_duty = '0; tgt_step = '0;
    tick(3);
    chk("reset_duty", duty, 0);
    chk("reset_ready", tgt_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_period_start", period_start, 1);
    reset = 1'b1;
    // ramp up 0 -> 64 by 16
    wait_ps(); tick(5);
    push(8'd16, 0); push(8'd32, 0); push(8'd48, 0); push(8'd64, 1);
    send(8'd64, 8'd16);
    chk("accept_no_duty_change", duty, 0);
    chk("ramp_busy", busy, 1);
    chk("ramp_ready_low", tgt_ready, 0);
    wait_idle();
    chk("up_final", duty, 64);
    // ramp down with non-multiple step
    push(8'd16, 0); push(8'd0, 1);
    send(8'd0, 8'd48);
    wait_idle();
    chk("down_final", duty, 0);
    // jump with step 0, then no-op target
    push(8'd192, 1);
    send(8'd192, 8'd0);
    wait_idle();
    chk("jump_final", duty, 192);
    push(8'd192, 1);
    send(8'd192, 8'd5);
    chk("noop_done_next_cycle", done, 1);
    chk("noop_not_busy", busy, 0);
    tick(2);
    // tgt_valid held during RAMP must not be latched
    wait_ps(); tick(5);
    push(8'd128, 0); push(8'd64, 1);
    send(8'd64, 8'd64);
    tgt_valid = 1'b1; tgt_duty = 8'd10; tgt_step = 8'd1;
    tick(100);
    chk("hold_valid_ready_low", tgt_ready, 0);
    chk("hold_valid_busy", busy, 1);
    tgt_valid = 1'b0;
    wait_idle();
    chk("hold_final", duty, 64);
    // accept exactly on the wrap edge
    wait_ps(); tick(255);
    push(8'd100, 1);
    send(8'd100, 8'd36);
    chk("wrap_accept_duty_held", duty, 64);
    chk("wrap_accept_period_start", period_start, 1);
    chk("wrap_accept_busy", busy, 1);
    k = 0;
    while (duty == 8'd64 && k < 400) begin tick(1); k++; end
    chk("wrap_accept_first_step_latency", k, 256);
    chk("wrap_accept_final", duty, 100);
    tick(2);
    // freeze mid-ramp, then reset mid-ramp
    push(8'd110, 0);
    send(8'd200, 8'd10);
    k = 0;
    while (duty == 8'd100 && k < 600) begin tick(1); k++; end
    chk("freeze_first_step", duty, 110);
    tick(10);
    enable = 1'b0;
    saw_ps = 1'b0;
    for (int i = 0; i < 300; i++) begin tick(1); saw_ps |= period_start; end
    chk("freeze_duty", duty, 110);
    chk("freeze_cnt_no_period_start", int'(saw_ps), 0);
    chk("freeze_busy", busy, 1);
    enable = 1'b1;
    tick(10);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    chk("midreset_duty", duty, 0);
    chk("midreset_ready", tgt_ready, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    tick(600);
    chk("midreset_stays_zero", duty, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
